// File: rtl/puf_eval_sequencer_if.sv
// Host-side challenge/response bundle for puf_eval_sequencer.
// The challenge request and the response return both use valid/ready handshakes.
// The host drives the master modport; the sequencer uses the slave modport.
interface puf_eval_sequencer_if #(
    parameter int N_BITS = 16,
    parameter int CW     = 16
);
    logic              start_valid;
    logic              start_ready;
    logic [CW-1:0]     challenge;
    logic              resp_valid;
    logic              resp_ready;
    logic [N_BITS-1:0] resp;
    logic [N_BITS-1:0] resp_unstable;

    modport master (
        output start_valid, challenge, resp_ready,
        input  start_ready, resp_valid, resp, resp_unstable
    );

    modport slave (
        input  start_valid, challenge, resp_ready,
        output start_ready, resp_valid, resp, resp_unstable
    );
endinterface

// File: rtl/puf_eval_sequencer.sv
// Sequencer for a bank of data-sensitive PUF latch cells.
// Each accepted challenge runs N_EVAL clear/apply/hold/sample evaluations.
// A per-cell ones counter feeds a majority vote, and any cell whose count is
// neither 0 nor N_EVAL is flagged as unstable.
// Every output is a register written on state transitions, so no input
// reaches an output combinationally.
module puf_eval_sequencer #(
    parameter int N_BITS     = 16,
    parameter int CW         = 16,
    parameter int SETTLE_CYC = 8,
    parameter int N_EVAL     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    puf_eval_sequencer_if.slave  host,
    output logic [CW-1:0]        chal_out,
    output logic                 latch_ld,
    output logic                 latch_clr,
    input  logic [N_BITS-1:0]    latch_q,
    output logic                 busy
);
    localparam int CNT_W = $clog2(N_EVAL + 1);
    localparam int SW    = $clog2(SETTLE_CYC + 1);

    localparam logic [CNT_W-1:0] HALF      = CNT_W'(N_EVAL / 2);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(N_EVAL);
    localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(N_EVAL - 1);
    localparam logic [SW-1:0]    SET_LAST  = SW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_APPLY, S_HOLD, S_SAMPLE, S_DONE
    } state_t;

    state_t                        r_state;
    logic [CW-1:0]                 r_chal;
    logic [N_BITS-1:0][CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]              r_eval;
    logic [SW-1:0]                 r_settle;

    logic [N_BITS-1:0][CNT_W-1:0]  w_cnt_next;
    logic [N_BITS-1:0]             w_resp_next;
    logic [N_BITS-1:0]             w_unst_next;

    // The vote is taken on the count that includes the final sample, so the
    // response can be registered on the same edge that enters DONE.
    genvar gi;
    generate
        for (gi = 0; gi < N_BITS; gi++) begin : g_bit
            assign w_cnt_next[gi]  = r_cnt[gi] + CNT_W'(latch_q[gi]);
            assign w_resp_next[gi] = (w_cnt_next[gi] > HALF);
            assign w_unst_next[gi] = (w_cnt_next[gi] != '0) && (w_cnt_next[gi] != FULL);
        end
    endgenerate

    // Main FSM: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_chal             <= '0;
            r_cnt              <= '0;
            r_eval             <= '0;
            r_settle           <= '0;
            host.start_ready   <= 1'b1;
            host.resp_valid    <= 1'b0;
            host.resp          <= '0;
            host.resp_unstable <= '0;
            busy               <= 1'b0;
            latch_ld           <= 1'b0;
            latch_clr          <= 1'b0;
            chal_out           <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (host.start_valid) begin
                        r_chal           <= host.challenge;
                        r_cnt            <= '0;
                        r_eval           <= '0;
                        host.start_ready <= 1'b0;
                        busy             <= 1'b1;
                        latch_clr        <= 1'b1;
                        chal_out         <= '0;
                        r_state          <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    // The D transition to zero during the clear cycle resets
                    // the cells; the challenge is driven from the next cycle.
                    latch_clr <= 1'b0;
                    latch_ld  <= 1'b1;
                    chal_out  <= r_chal;
                    r_settle  <= '0;
                    r_state   <= S_APPLY;
                end
                S_APPLY: begin
                    if (r_settle == SET_LAST) begin
                        latch_ld <= 1'b0;
                        r_state  <= S_HOLD;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_HOLD: begin
                    r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    r_cnt    <= w_cnt_next;
                    r_eval   <= r_eval + 1'b1;
                    chal_out <= '0;
                    if (r_eval == EVAL_LAST) begin
                        host.resp          <= w_resp_next;
                        host.resp_unstable <= w_unst_next;
                        host.resp_valid    <= 1'b1;
                        r_state            <= S_DONE;
                    end else begin
                        latch_clr <= 1'b1;
                        r_state   <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    if (host.resp_ready) begin
                        host.resp_valid  <= 1'b0;
                        host.start_ready <= 1'b1;
                        busy             <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    host.start_ready <= 1'b1;
                    host.resp_valid  <= 1'b0;
                    busy             <= 1'b0;
                    latch_ld         <= 1'b0;
                    latch_clr        <= 1'b0;
                    chal_out         <= '0;
                end
            endcase
        end
    end
endmodule
